// File: rtl/ne_fp_sfr_align_pipe_w16s4_pkg.sv
// rtl/ne_fp_sfr_align_pipe_w16s4_pkg.sv - shared constants and fill helper for the alignment right shifter
package ne_fp_sfr_align_pipe_w16s4_pkg;

    // Internal shift-index width; narrower shift ports are zero-extended to this.
    localparam int NE_FP_SF_MAX = 6;

    function automatic logic fill_of(input logic msb, input bit signed_mode);
        return signed_mode & msb;
    endfunction

endpackage

// File: rtl/ne_fp_sfr_blk.sv
// rtl/ne_fp_sfr_blk.sv - combinational right-shift slice covering levels LVL_LO..LVL_HI with sticky
module ne_fp_sfr_blk
    import ne_fp_sfr_align_pipe_w16s4_pkg::*;
#(
    parameter int BW_DATA = 16,
    parameter int SIGNED  = 0,
    parameter int LVL_LO  = 0,
    parameter int LVL_HI  = 1
) (
    input  logic [BW_DATA-1:0]     a,
    input  logic [LVL_HI-LVL_LO:0] ss,
    input  logic                   fill,
    input  logic                   sticky_in,
    output logic [BW_DATA-1:0]     z,
    output logic                   sticky_out
);

    localparam logic [BW_DATA-1:0] ONES = '1;

    logic fill_eff;

    assign fill_eff = fill_of(fill, SIGNED != 0);

    // ss[k] selects a shift of 2**(LVL_LO+k); levels at or beyond the word width saturate.
    always_comb begin
        z          = a;
        sticky_out = sticky_in;
        for (int k = 0; k <= LVL_HI - LVL_LO; k++) begin
            if (ss[k]) begin
                if ((1 << (LVL_LO + k)) >= BW_DATA) begin
                    sticky_out = sticky_out | (|z);
                    z          = {BW_DATA{fill_eff}};
                end else begin
                    sticky_out = sticky_out | (|(z & ~(ONES << (1 << (LVL_LO + k)))));
                    z          = (z >> (1 << (LVL_LO + k)))
                               | ({BW_DATA{fill_eff}} & ~(ONES >> (1 << (LVL_LO + k))));
                end
            end
        end
    end

endmodule

// File: rtl/ne_fp_sfr_align_pipe_w16s4.sv
// rtl/ne_fp_sfr_align_pipe_w16s4.sv - two-stage pipelined exponent-alignment right shifter with sticky
module ne_fp_sfr_align_pipe_w16s4
    import ne_fp_sfr_align_pipe_w16s4_pkg::*;
#(
    parameter int BW_DATA = 16,
    parameter int BW_SF   = 4,
    parameter int SIGNED  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [BW_DATA-1:0] in_data,
    input  logic [BW_SF-1:0]   in_sft,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [BW_DATA-1:0] out_data,
    output logic               out_sticky
);

    localparam int SW = NE_FP_SF_MAX;

    logic [SW-1:0]      ss;
    logic               in_fill;
    logic               adv1;
    logic               adv2;
    logic               in_fire;
    logic [BW_DATA-1:0] s1_data_d;
    logic [BW_DATA-1:0] s1_data_q;
    logic [SW-3:0]      s1_sft_q;
    logic               s1_sticky_d;
    logic               s1_sticky_q;
    logic               s1_fill_q;
    logic               s1_vld_q;
    logic [BW_DATA-1:0] out_data_d;
    logic [BW_DATA-1:0] out_data_q;
    logic               out_sticky_d;
    logic               out_sticky_q;
    logic               out_vld_q;

    assign ss      = SW'(in_sft);
    assign in_fill = fill_of(in_data[BW_DATA-1], SIGNED != 0);

    assign adv2    = !out_vld_q || out_rdy;
    assign adv1    = !s1_vld_q || adv2;
    assign in_rdy  = adv1 && rst_n;
    assign in_fire = in_vld && in_rdy;

    ne_fp_sfr_blk #(
        .BW_DATA (BW_DATA),
        .SIGNED  (SIGNED),
        .LVL_LO  (0),
        .LVL_HI  (1)
    ) u_stage1 (
        .a          (in_data),
        .ss         (ss[1:0]),
        .fill       (in_fill),
        .sticky_in  (1'b0),
        .z          (s1_data_d),
        .sticky_out (s1_sticky_d)
    );

    ne_fp_sfr_blk #(
        .BW_DATA (BW_DATA),
        .SIGNED  (SIGNED),
        .LVL_LO  (2),
        .LVL_HI  (SW-1)
    ) u_stage2 (
        .a          (s1_data_q),
        .ss         (s1_sft_q),
        .fill       (s1_fill_q),
        .sticky_in  (s1_sticky_q),
        .z          (out_data_d),
        .sticky_out (out_sticky_d)
    );

    // Payload registers only load with a valid beat so a stalled output never changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q     <= 1'b0;
            s1_data_q    <= '0;
            s1_sft_q     <= '0;
            s1_sticky_q  <= 1'b0;
            s1_fill_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
            out_sticky_q <= 1'b0;
        end else begin
            if (adv1) begin
                s1_vld_q <= in_fire;
                if (in_fire) begin
                    s1_data_q   <= s1_data_d;
                    s1_sft_q    <= ss[SW-1:2];
                    s1_sticky_q <= s1_sticky_d;
                    s1_fill_q   <= in_fill;
                end
            end
            if (adv2) begin
                out_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    out_data_q   <= out_data_d;
                    out_sticky_q <= out_sticky_d;
                end
            end
        end
    end

    assign out_vld    = out_vld_q;
    assign out_data   = out_data_q;
    assign out_sticky = out_sticky_q;

endmodule

// File: tb/tb_ne_fp_sfr_align_pipe_w16s4.sv
// tb/tb_ne_fp_sfr_align_pipe_w16s4.sv - directed and random checks of the alignment shifter pipeline
module tb_ne_fp_sfr_align_pipe_w16s4;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic        out_rdy;
    logic [15:0] in_data;
    logic [5:0]  sft;

    logic        in_rdy0, out_vld0, out_sticky0;
    logic [15:0] out_data0;
    logic        in_rdy1, out_vld1, out_sticky1;
    logic [15:0] out_data1;

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int base;
    int prev;
    bit rdy_low_seen;
    bit hold_chk = 0;
    logic [15:0] hold_data;
    logic        hold_stk;
    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [15:0] popped0[$];

    ne_fp_sfr_align_pipe_w16s4 u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy0),
        .in_data    (in_data),
        .in_sft     (sft[3:0]),
        .out_vld    (out_vld0),
        .out_rdy    (out_rdy),
        .out_data   (out_data0),
        .out_sticky (out_sticky0)
    );

    ne_fp_sfr_align_pipe_w16s4 #(
        .BW_DATA (16),
        .BW_SF   (6),
        .SIGNED  (1)
    ) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy1),
        .in_data    (in_data),
        .in_sft     (sft),
        .out_vld    (out_vld1),
        .out_rdy    (out_rdy),
        .out_data   (out_data1),
        .out_sticky (out_sticky1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: one position per iteration, catching each bit that falls off.
    function automatic logic [16:0] ref_shift(input logic [15:0] d, input int s, input bit sgn);
        logic [15:0] r;
        logic        st;
        logic        f;
        r  = d;
        st = 1'b0;
        f  = sgn & d[15];
        for (int i = 0; i < s; i++) begin
            st = st | r[0];
            r  = {f, r[15:1]};
        end
        return {st, r};
    endfunction

    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            hold_chk = 0;
        end else begin
            if (hold_chk) begin
                chk("hold_vld", out_vld0, 1);
                chk("hold_data", out_data0, hold_data);
                chk("hold_stk", out_sticky0, hold_stk);
            end
            if (out_vld0 && out_rdy) begin
                popped0.push_back(out_data0);
                if (q0.size() == 0) chk("sb0_underflow", out_vld0, 0);
                else begin
                    e = q0.pop_front();
                    chk("sb0", {out_sticky0, out_data0}, e);
                end
            end
            if (out_vld1 && out_rdy) begin
                if (q1.size() == 0) chk("sb1_underflow", out_vld1, 0);
                else begin
                    e = q1.pop_front();
                    chk("sb1", {out_sticky1, out_data1}, e);
                end
            end
            if (!in_rdy0) rdy_low_seen = 1;
            if (in_vld && in_rdy0) begin
                q0.push_back(ref_shift(in_data, int'(sft[3:0]), 1'b0));
                acc_cnt++;
            end
            if (in_vld && in_rdy1) q1.push_back(ref_shift(in_data, int'(sft), 1'b1));
            hold_chk  = out_vld0 && !out_rdy;
            hold_data = out_data0;
            hold_stk  = out_sticky0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [15:0] d, input logic [5:0] s,
                       input logic [15:0] e0, input logic e0s,
                       input logic [15:0] e1, input logic e1s);
        in_vld  = 1'b1;
        in_data = d;
        sft     = s;
        step();
        in_vld = 1'b0;
        chk("lat_vld0", out_vld0, 0);
        step();
        chk("dir_vld0", out_vld0, 1);
        chk("dir_data0", out_data0, e0);
        chk("dir_stk0", out_sticky0, e0s);
        chk("dir_data1", out_data1, e1);
        chk("dir_stk1", out_sticky1, e1s);
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        in_data = '0;
        sft     = '0;
        step();
        step();
        chk("rst_vld0", out_vld0, 0);
        chk("rst_data0", out_data0, 0);
        chk("rst_stk0", out_sticky0, 0);
        chk("rst_vld1", out_vld1, 0);
        chk("rst_in_rdy", in_rdy0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_rdy", in_rdy0, 1);
        step();

        // data, shift, unsigned/4-bit result, signed/6-bit result
        one(16'h8000, 6'd4,  16'h0800, 1'b0, 16'hF800, 1'b0);
        one(16'h00FF, 6'd4,  16'h000F, 1'b1, 16'h000F, 1'b1);
        one(16'h00FF, 6'd0,  16'h00FF, 1'b0, 16'h00FF, 1'b0);
        one(16'h8001, 6'd15, 16'h0001, 1'b1, 16'hFFFF, 1'b1);
        one(16'hF000, 6'd8,  16'h00F0, 1'b0, 16'hFFF0, 1'b0);
        one(16'h1234, 6'd40, 16'h0012, 1'b1, 16'h0000, 1'b1);
        one(16'h0001, 6'd16, 16'h0001, 1'b0, 16'h0000, 1'b1);
        one(16'h0000, 6'd63, 16'h0000, 1'b0, 16'h0000, 1'b0);
        one(16'h8000, 6'd16, 16'h8000, 1'b0, 16'hFFFF, 1'b1);
        step();

        // Back-to-back stream with a three-cycle downstream stall
        rdy_low_seen = 0;
        popped0.delete();
        base = acc_cnt;
        sft  = '0;
        for (int c = 1; c <= 14; c++) begin
            if (acc_cnt - base < 5) begin
                in_vld  = 1'b1;
                in_data = 16'(acc_cnt - base + 1);
            end else begin
                in_vld = 1'b0;
            end
            out_rdy = !(c >= 3 && c <= 5);
            step();
        end
        chk("stream_count", popped0.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("stream_order", (i < popped0.size()) ? popped0[i] : 16'hDEAD, i + 1);
        chk("stall_rdy_low", rdy_low_seen, 1);

        // Reset with both stages occupied
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_data = 16'h0AAA;
        step();
        in_data = 16'h0BBB;
        step();
        in_vld = 1'b0;
        chk("pre_rst_vld", out_vld0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_rdy_mid", in_rdy0, 0);
        step();
        chk("rst2_vld0", out_vld0, 0);
        chk("rst2_data0", out_data0, 0);
        chk("rst2_stk0", out_sticky0, 0);
        chk("rst2_vld1", out_vld1, 0);
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        one(16'h0F0F, 6'd4, 16'h00F0, 1'b1, 16'h00F0, 1'b1);
        step();
        chk("no_stale_vld", out_vld0, 0);

        // Random traffic with random backpressure
        base   = acc_cnt;
        prev   = acc_cnt;
        in_vld = 1'b0;
        for (int c = 0; c < 40000 && (acc_cnt - base) < 10000; c++) begin
            if (!in_vld || acc_cnt != prev) begin
                in_vld  = ($urandom_range(0, 3) != 0);
                in_data = 16'($urandom);
                sft     = 6'($urandom_range(0, 63));
            end
            prev    = acc_cnt;
            out_rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        in_vld = 1'b0;
        chk("rand_accepted", acc_cnt - base, 10000);
        out_rdy = 1'b1;
        for (int c = 0; c < 20 && (q0.size() != 0 || q1.size() != 0); c++) step();
        chk("drain0", q0.size(), 0);
        chk("drain1", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
